rcc_switch_ctrl: RTL and testbench
==================================

// Module: rcc_switch_ctrl
// PURPOSE
//  Request-side sequencer that drives rcc_cr of the three-clock glitch-free system clock switch.
//  - Accepts a clock-select request over a valid/ready handshake.
//  - Waits for the target oscillator's ready status, then drives rcc_cr.
//  - Holds busy for a fixed settle window, then reports done.
//  - Fail-safe: falls back to clk_10M whenever the active source loses ready.
//  - Sits between the register/bus slave and the clock switch; runs entirely on clk_10M.
// PARAMETERS
//  SETTLE_CYCLES  2048  clk_10M cycles rcc_cr is held before done (covers ~6 clk_32K periods)
//  RDY_TIMEOUT    4096  clk_10M cycles to wait for target osc ready before error
//  SYNC_STAGES    2     flop stages on each osc_rdy input (>=2)
// PORTS
//  clk_10M    in   1  block clock, 10 MHz, always running
//  rst_n      in   1  reset, asynchronous, active-low
//  req_valid  in   1  select request valid
//  req_sel    in   2  requested source: 00=10M, 01=32K, 10=100M, 11=illegal
//  req_ready  out  1  request accepted when req_valid & req_ready at posedge
//  osc_rdy    in   3  async ready: [0]=10M (ignored, forced 1), [1]=32K, [2]=100M lock
//  rcc_cr     out  2  select code to clock switch, registered
//  cur_sel    out  2  source confirmed active (updated on done/fallback)
//  busy       out  1  high when state != IDLE
//  done       out  1  1-cycle pulse: request completed
//  err        out  1  1-cycle pulse: request failed or fallback taken
//  err_code   out  2  valid with err: 01 illegal sel, 10 ready timeout, 11 source lost; holds last value
// BEHAVIOUR
//  Reset values: rcc_cr=00, cur_sel=00, req_ready=1, busy=0, done=0, err=0, err_code=00, FSM=IDLE.
//  Reset mid-operation aborts any sequence and restores all reset values.
//  Sync: osc_rdy[2:1] pass through SYNC_STAGES flops (reset 0) -> rdy_s; rdy_s[0] tied 1.
//  FSM states: IDLE, CHECK, WAIT_RDY, SWITCH. req_ready = (state==IDLE); busy = ~req_ready.
//  IDLE: on handshake, latch tgt<=req_sel; go to CHECK.
//  CHECK (1 cycle):
//   - tgt==11: err=1, err_code=01; go to IDLE; rcc_cr unchanged.
//   - tgt==cur_sel: done=1; go to IDLE; no rcc_cr change.
//   - otherwise: clear counter; go to WAIT_RDY.
//  WAIT_RDY:
//   - rdy_s[tgt]==1: rcc_cr<=tgt on the same edge; clear counter; go to SWITCH.
//   - otherwise counter++. At count==RDY_TIMEOUT-1: err=1, err_code=10; go to IDLE; rcc_cr unchanged.
//  SWITCH: counter++. At count==SETTLE_CYCLES-1: cur_sel<=tgt, done=1; go to IDLE.
//   - If rdy_s[tgt] drops during SWITCH: fallback (below).
//  Fallback (highest priority, any state):
//   - Trigger: rdy_s[cur_sel]==0 with cur_sel!=00, or the SWITCH condition above.
//   - Action: rcc_cr<=00, cur_sel<=00, err=1, err_code=11, FSM<=IDLE; pending request dropped.
//  Fallback beats done/err of the same cycle; only one of done/err pulses per cycle.
//  Latency: accept -> done (same-sel) = 2 edges. Accept -> rcc_cr change = 3 edges min.
//   rcc_cr change -> done = SETTLE_CYCLES edges.
//  Counter width: clog2(max(SETTLE_CYCLES,RDY_TIMEOUT)); no wrap, cleared on every state entry.
//  req_sel is sampled only at handshake; changes while busy are ignored.
// TESTING
//  1 reset, osc_rdy=000: rcc_cr=00, cur_sel=00, req_ready=1, no pulses.
//  2 osc_rdy=110 (held), req 10: rcc_cr=10 3 edges after accept; done 2048 edges later; cur_sel=10.
//  3 req 11: err pulse, err_code=01, 2 edges after accept; rcc_cr unchanged.
//    Then req 00 while cur_sel=00: done 2 edges after accept.
//  4 osc_rdy=000, req 01: err_code=10 after 4096 WAIT_RDY cycles; rcc_cr stays 00.
//  5 cur_sel=01 steady, deassert osc_rdy[1]: err_code=11, rcc_cr=00, cur_sel=00 within SYNC_STAGES+1 edges.
//  6 rst_n low mid-SWITCH (rcc_cr=10): all outputs return to reset values immediately.
//    After release, req_ready=1 and rcc_cr=00.

Source files
------------

// File: rtl/rcc_switch_ctrl.sv
// Request-side sequencer for the three-clock glitch-free system clock switch.
// Accepts a source select, waits for the oscillator to be ready, drives rcc_cr and settles.
module rcc_switch_ctrl #(
    parameter int SETTLE_CYCLES = 2048,
    parameter int RDY_TIMEOUT   = 4096,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk_10M,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic [2:0] osc_rdy,
    output logic [1:0] rcc_cr,
    output logic [1:0] cur_sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int CNT_MAX = (SETTLE_CYCLES > RDY_TIMEOUT) ? SETTLE_CYCLES : RDY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_RDY = 2'd2,
        SWITCH   = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       tgt, tgt_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       rcc_cr_nx;
    logic [1:0]       cur_sel_nx;
    logic             done_nx;
    logic             err_nx;
    logic [1:0]       err_code_nx;
    logic             fallback;

    logic [1:0]       sync_q [SYNC_STAGES];
    logic [3:0]       rdy_s;
    logic             unused_osc10m;

    // The 10 MHz oscillator is the block clock itself, so its ready bit is meaningless.
    assign unused_osc10m = osc_rdy[0];

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= osc_rdy[2:1];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Bit 3 pads the illegal code so every 2-bit index stays in range.
    assign rdy_s = {1'b0, sync_q[SYNC_STAGES-1], 1'b1};

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    assign fallback = ((cur_sel != 2'b00) && !rdy_s[cur_sel]) ||
                      ((state == SWITCH) && !rdy_s[tgt]);

    always_comb begin
        state_nx    = state;
        tgt_nx      = tgt;
        cnt_nx      = cnt;
        rcc_cr_nx   = rcc_cr;
        cur_sel_nx  = cur_sel;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        err_code_nx = err_code;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    tgt_nx   = req_sel;
                    cnt_nx   = '0;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                cnt_nx = '0;
                if (tgt == 2'b11) begin
                    err_nx      = 1'b1;
                    err_code_nx = 2'b01;
                    state_nx    = IDLE;
                end else if (tgt == cur_sel) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (rdy_s[tgt]) begin
                    rcc_cr_nx = tgt;
                    cnt_nx    = '0;
                    state_nx  = SWITCH;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_nx      = 1'b1;
                    err_code_nx = 2'b10;
                    cnt_nx      = '0;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            SWITCH: begin
                if (cnt == SETTLE_LAST) begin
                    cur_sel_nx = tgt;
                    done_nx    = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Losing the active or incoming source overrides whatever the FSM decided.
        if (fallback) begin
            rcc_cr_nx   = 2'b00;
            cur_sel_nx  = 2'b00;
            done_nx     = 1'b0;
            err_nx      = 1'b1;
            err_code_nx = 2'b11;
            cnt_nx      = '0;
            state_nx    = IDLE;
        end
    end

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tgt      <= 2'b00;
            cnt      <= '0;
            rcc_cr   <= 2'b00;
            cur_sel  <= 2'b00;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= state_nx;
            tgt      <= tgt_nx;
            cnt      <= cnt_nx;
            rcc_cr   <= rcc_cr_nx;
            cur_sel  <= cur_sel_nx;
            done     <= done_nx;
            err      <= err_nx;
            err_code <= err_code_nx;
        end
    end

endmodule

// File: tb/tb_rcc_switch_ctrl.sv
// Directed bench for rcc_switch_ctrl: select, settle, timeout, illegal select,
// source-loss fallback and mid-sequence reset, all with hand-computed edge counts.
module tb_rcc_switch_ctrl;

    logic       clk_10M   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel   = 2'b00;
    logic [2:0] osc_rdy   = 3'b000;
    logic       req_ready;
    logic [1:0] rcc_cr;
    logic [1:0] cur_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int compared   = 0;
    int mismatched = 0;

    rcc_switch_ctrl dut (
        .clk_10M   (clk_10M),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .osc_rdy   (osc_rdy),
        .rcc_cr    (rcc_cr),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #50 clk_10M = ~clk_10M;

    task stepEdge();
        @(posedge clk_10M);
        #1;
    endtask

    task stepEdges(input int n);
        for (int i = 0; i < n; i++) begin
            stepEdge();
        end
    endtask

    task checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One handshake edge; req_sel is then scrambled to show it is ignored while busy.
    task applyStimulus(input logic [1:0] sel);
        checkOutput("ready_before_req", {3'b0, req_ready}, 4'h1);
        req_valid = 1'b1;
        req_sel   = sel;
        stepEdge();
        req_valid = 1'b0;
        req_sel   = 2'b11;
    endtask

    task waitQuiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            stepEdge();
            if (done || err) seen = 1'b1;
        end
        checkOutput(tag, {3'b0, seen}, 4'h0);
    endtask

    task checkResetOutputs(input string tag);
        checkOutput({tag, "_rcc_cr"},    {2'b0, rcc_cr},   4'h0);
        checkOutput({tag, "_cur_sel"},   {2'b0, cur_sel},  4'h0);
        checkOutput({tag, "_req_ready"}, {3'b0, req_ready}, 4'h1);
        checkOutput({tag, "_busy"},      {3'b0, busy},     4'h0);
        checkOutput({tag, "_done"},      {3'b0, done},     4'h0);
        checkOutput({tag, "_err"},       {3'b0, err},      4'h0);
        checkOutput({tag, "_err_code"},  {2'b0, err_code}, 4'h0);
    endtask

    initial begin
        $display("[TB] start");

        // Reset with no oscillators ready
        #120;
        checkResetOutputs("reset");
        @(negedge clk_10M);
        rst_n = 1'b1;
        waitQuiet("post_reset_quiet", 3);

        // Illegal select, then same-source request
        applyStimulus(2'b11);
        checkOutput("ill_busy", {3'b0, busy}, 4'h1);
        checkOutput("ill_err_early", {3'b0, err}, 4'h0);
        stepEdge();
        checkOutput("ill_err", {3'b0, err}, 4'h1);
        checkOutput("ill_code", {2'b0, err_code}, 4'h1);
        checkOutput("ill_done", {3'b0, done}, 4'h0);
        checkOutput("ill_rcc", {2'b0, rcc_cr}, 4'h0);
        stepEdge();
        checkOutput("ill_err_pulse", {3'b0, err}, 4'h0);
        applyStimulus(2'b00);
        stepEdge();
        checkOutput("same_done", {3'b0, done}, 4'h1);
        checkOutput("same_err", {3'b0, err}, 4'h0);
        checkOutput("same_ready", {3'b0, req_ready}, 4'h1);
        stepEdge();
        checkOutput("same_done_pulse", {3'b0, done}, 4'h0);
        checkOutput("err_code_hold", {2'b0, err_code}, 4'h1);

        // Switch to 100M
        osc_rdy = 3'b110;
        stepEdges(3);
        applyStimulus(2'b10);
        stepEdge();
        checkOutput("sw100_rcc_e2", {2'b0, rcc_cr}, 4'h0);
        stepEdge();
        checkOutput("sw100_rcc_e3", {2'b0, rcc_cr}, 4'h2);
        checkOutput("sw100_cur_e3", {2'b0, cur_sel}, 4'h0);
        checkOutput("sw100_busy", {3'b0, busy}, 4'h1);
        waitQuiet("sw100_settle_quiet", 2047);
        stepEdge();
        checkOutput("sw100_done", {3'b0, done}, 4'h1);
        checkOutput("sw100_cur", {2'b0, cur_sel}, 4'h2);
        stepEdge();
        checkOutput("sw100_done_pulse", {3'b0, done}, 4'h0);

        // Switch to 32K, then lose it while it is the active source
        applyStimulus(2'b01);
        stepEdges(2);
        checkOutput("sw32_rcc", {2'b0, rcc_cr}, 4'h1);
        waitQuiet("sw32_settle_quiet", 2047);
        stepEdge();
        checkOutput("sw32_done", {3'b0, done}, 4'h1);
        checkOutput("sw32_cur", {2'b0, cur_sel}, 4'h1);
        stepEdge();
        @(negedge clk_10M);
        osc_rdy = 3'b100;
        stepEdges(2);
        checkOutput("lost_err_early", {3'b0, err}, 4'h0);
        checkOutput("lost_cur_early", {2'b0, cur_sel}, 4'h1);
        stepEdge();
        checkOutput("lost_err", {3'b0, err}, 4'h1);
        checkOutput("lost_code", {2'b0, err_code}, 4'h3);
        checkOutput("lost_rcc", {2'b0, rcc_cr}, 4'h0);
        checkOutput("lost_cur", {2'b0, cur_sel}, 4'h0);
        stepEdge();

        // Ready timeout on 32K
        osc_rdy = 3'b000;
        stepEdges(3);
        applyStimulus(2'b01);
        waitQuiet("tmo_quiet", 4096);
        stepEdge();
        checkOutput("tmo_err", {3'b0, err}, 4'h1);
        checkOutput("tmo_code", {2'b0, err_code}, 4'h2);
        checkOutput("tmo_rcc", {2'b0, rcc_cr}, 4'h0);
        stepEdge();
        checkOutput("tmo_ready", {3'b0, req_ready}, 4'h1);

        // Target drops during the settle window
        osc_rdy = 3'b010;
        stepEdges(3);
        applyStimulus(2'b01);
        stepEdges(2);
        checkOutput("swdrop_rcc", {2'b0, rcc_cr}, 4'h1);
        stepEdges(10);
        @(negedge clk_10M);
        osc_rdy = 3'b000;
        stepEdges(2);
        checkOutput("swdrop_err_early", {3'b0, err}, 4'h0);
        stepEdge();
        checkOutput("swdrop_err", {3'b0, err}, 4'h1);
        checkOutput("swdrop_code", {2'b0, err_code}, 4'h3);
        checkOutput("swdrop_rcc_back", {2'b0, rcc_cr}, 4'h0);
        checkOutput("swdrop_done", {3'b0, done}, 4'h0);
        checkOutput("swdrop_ready", {3'b0, req_ready}, 4'h1);
        stepEdge();

        // Reset in the middle of SWITCH
        osc_rdy = 3'b110;
        stepEdges(3);
        applyStimulus(2'b10);
        stepEdges(2);
        checkOutput("rst_mid_rcc_before", {2'b0, rcc_cr}, 4'h2);
        stepEdges(50);
        #10;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        stepEdges(2);
        @(negedge clk_10M);
        rst_n = 1'b1;
        stepEdge();
        checkOutput("rst_rel_ready", {3'b0, req_ready}, 4'h1);
        checkOutput("rst_rel_rcc", {2'b0, rcc_cr}, 4'h0);
        applyStimulus(2'b00);
        stepEdge();
        checkOutput("rst_rel_same_done", {3'b0, done}, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
